// File: rtl/computer_ctrl_pkg.sv
// Shared types and widths for the MIPS computer run sequencer.
package computer_ctrl_pkg;

  localparam int unsigned CPU_ADDR_W = 16;
  localparam int unsigned CPU_DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    RESET,
    RUN,
    STEP_WAIT,
    STEP,
    DONE
  } run_state_t;

endpackage

// File: rtl/computer_run_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (en && (count_q != '1)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/computer_run_controller.sv
// Run sequencer: resets the CPU, gates its clock (free-run or single-step) and stops it
// on a watched end-of-program store, a cycle limit or an abort.
module computer_run_controller
  import computer_ctrl_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  step_mode,
  input  logic                  step,
  input  logic                  abort,
  input  logic [CPU_ADDR_W-1:0] watch_addr,
  input  logic [CPU_DATA_W-1:0] watch_data,
  input  logic [CNT_W-1:0]      max_cycles,
  input  logic                  memwrite,
  input  logic [CPU_ADDR_W-1:0] dataadr,
  input  logic [CPU_DATA_W-1:0] writedata,
  output logic                  cpu_reset,
  output logic                  cpu_clk_en,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [CNT_W-1:0]      cycle_count
);

  localparam int unsigned RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES + 1) : 1;
  // A zero-length reset phase would never reset the CPU, so treat it as one cycle.
  localparam logic [RST_W-1:0] RST_LOAD = (RESET_CYCLES == 0) ? RST_W'(1) : RST_W'(RESET_CYCLES);

  run_state_t       state_q, state_d;
  logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
  logic             step_mode_q, step_mode_d;
  logic             pass_q, pass_d;
  logic             timeout_q, timeout_d;

  logic counting;
  logic match;
  logic limit_hit;
  logic cnt_clear;

  assign cpu_reset  = (state_q == IDLE) || (state_q == RESET);
  assign cpu_clk_en = (state_q == RESET) || (state_q == RUN) || (state_q == STEP);
  assign busy       = (state_q == RESET) || (state_q == RUN) ||
                      (state_q == STEP_WAIT) || (state_q == STEP);
  assign done       = (state_q == DONE);
  assign pass       = pass_q;
  assign timeout    = timeout_q;

  assign counting  = (state_q == RUN) || (state_q == STEP);
  assign match     = cpu_clk_en && memwrite && (dataadr == watch_addr) &&
                     (writedata == watch_data);
  // Widened compare so a saturated count cannot wrap into a false limit hit.
  assign limit_hit = counting && (max_cycles != '0) &&
                     (({1'b0, cycle_count} + (CNT_W + 1)'(1)) == {1'b0, max_cycles});

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    step_mode_d = step_mode_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    cnt_clear   = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = RESET;
          rst_cnt_d   = RST_LOAD;
          step_mode_d = step_mode;
          pass_d      = 1'b0;
          timeout_d   = 1'b0;
          cnt_clear   = 1'b1;
        end
      end
      RESET: begin
        if (rst_cnt_q <= RST_W'(1)) begin
          state_d = step_mode_q ? STEP_WAIT : RUN;
        end else begin
          rst_cnt_d = rst_cnt_q - RST_W'(1);
        end
      end
      RUN: ;
      STEP_WAIT: begin
        if (step) begin
          state_d = STEP;
        end
      end
      STEP: state_d = STEP_WAIT;
      default: state_d = IDLE;
    endcase

    // Run-ending events override the normal sequencing; abort > match > timeout.
    if (busy) begin
      if (abort) begin
        state_d = DONE;
      end else if (match) begin
        state_d = DONE;
        pass_d  = 1'b1;
      end else if (limit_hit) begin
        state_d   = DONE;
        timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rst_cnt_q   <= '0;
      step_mode_q <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      step_mode_q <= step_mode_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_cycle_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (cnt_clear),
    .en     (counting),
    .count  (cycle_count)
  );

endmodule

// File: tb/tb_computer_run_controller.sv
// Directed self-checking bench for computer_run_controller.
module tb_computer_run_controller;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        step_mode;
  logic        step;
  logic        abort;
  logic [15:0] watch_addr;
  logic [15:0] watch_data;
  logic [15:0] max_cycles;
  logic        memwrite;
  logic [15:0] dataadr;
  logic [15:0] writedata;
  logic        cpu_reset;
  logic        cpu_clk_en;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [15:0] cycle_count;

  int n_checks = 0;
  int n_pass   = 0;
  int en_cyc;

  computer_run_controller #(
    .RESET_CYCLES(2),
    .CNT_W       (16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .step_mode  (step_mode),
    .step       (step),
    .abort      (abort),
    .watch_addr (watch_addr),
    .watch_data (watch_data),
    .max_cycles (max_cycles),
    .memwrite   (memwrite),
    .dataadr    (dataadr),
    .writedata  (writedata),
    .cpu_reset  (cpu_reset),
    .cpu_clk_en (cpu_clk_en),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .timeout    (timeout),
    .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic mode);
    step_mode = mode;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Free-run until done; drives the matching store or abort in the given run cycle (0 = never).
  task automatic run_phase(input int match_at, input int abort_at, output int en_out);
    int en;
    en = 0;
    for (int i = 0; i < 400; i++) begin
      if (done) break;
      if (cpu_clk_en && !cpu_reset) en++;
      memwrite  = (match_at != 0) && (en == match_at);
      abort     = (abort_at != 0) && (en == abort_at);
      dataadr   = 16'd64;
      writedata = 16'h0096;
      tick();
    end
    memwrite = 1'b0;
    abort    = 1'b0;
    check("run_terminates", {31'd0, done}, 32'd1);
    en_out = en;
  endtask

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    step_mode  = 1'b0;
    step       = 1'b0;
    abort      = 1'b0;
    watch_addr = 16'd64;
    watch_data = 16'h0096;
    max_cycles = 16'd100;
    memwrite   = 1'b0;
    dataadr    = 16'd0;
    writedata  = 16'd0;

    // 1. Reset values
    tick();
    tick();
    check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("rst_clk_en", {31'd0, cpu_clk_en}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_count", {16'd0, cycle_count}, 32'd0);
    reset_n = 1'b1;
    tick();

    // 2. Free-run pass in run cycle 10
    pulse_start(1'b0);
    check("p_reset_ph", {30'd0, cpu_reset, cpu_clk_en}, 32'b11);
    check("p_busy", {31'd0, busy}, 32'd1);
    run_phase(10, 0, en_cyc);
    check("p_done", {31'd0, done}, 32'd1);
    check("p_pass", {31'd0, pass}, 32'd1);
    check("p_timeout", {31'd0, timeout}, 32'd0);
    check("p_count", {16'd0, cycle_count}, 32'd10);
    check("p_clk_en", {31'd0, cpu_clk_en}, 32'd0);
    check("p_en_cycles", en_cyc, 32'd10);
    tick();
    check("p_hold", {15'd0, pass, cycle_count}, {15'd0, 1'b1, 16'd10});

    // 3. Timeout at 20 cycles
    max_cycles = 16'd20;
    pulse_start(1'b0);
    check("t_cleared", {14'd0, pass, timeout, cycle_count}, 32'd0);
    run_phase(0, 0, en_cyc);
    check("t_timeout", {31'd0, timeout}, 32'd1);
    check("t_pass", {31'd0, pass}, 32'd0);
    check("t_count", {16'd0, cycle_count}, 32'd20);
    check("t_en_cycles", en_cyc, 32'd20);

    // 4a. Match coinciding with the limit cycle: pass wins
    pulse_start(1'b0);
    run_phase(20, 0, en_cyc);
    check("tie_pass", {31'd0, pass}, 32'd1);
    check("tie_timeout", {31'd0, timeout}, 32'd0);
    check("tie_count", {16'd0, cycle_count}, 32'd20);

    // 5. Step mode, including a matching write while parked in STEP_WAIT
    max_cycles = 16'd0;
    pulse_start(1'b1);
    tick();
    tick();
    check("s_wait_clk_en", {31'd0, cpu_clk_en}, 32'd0);
    check("s_wait_busy", {31'd0, busy}, 32'd1);
    memwrite  = 1'b1;
    dataadr   = 16'd64;
    writedata = 16'h0096;
    tick();
    memwrite = 1'b0;
    check("s_ignored_write", {30'd0, done, pass}, 32'd0);
    en_cyc = 0;
    for (int i = 0; i < 16; i++) begin
      if (cpu_clk_en) en_cyc++;
      step = (i == 0) || (i == 1) || (i == 4) || (i == 8);
      tick();
    end
    step = 1'b0;
    check("s_en_cycles", en_cyc, 32'd3);
    check("s_count", {16'd0, cycle_count}, 32'd3);
    check("s_not_done", {31'd0, done}, 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("s_abort_done", {29'd0, done, pass, timeout}, 32'b100);

    // 6. Abort at run cycle 5, restart, start ignored while busy, async reset mid-run
    max_cycles = 16'd100;
    pulse_start(1'b0);
    run_phase(0, 5, en_cyc);
    check("a_flags", {30'd0, pass, timeout}, 32'd0);
    check("a_count", {16'd0, cycle_count}, 32'd5);
    pulse_start(1'b0);
    check("r_count_clr", {16'd0, cycle_count}, 32'd0);
    check("r_reset1", {30'd0, cpu_reset, done}, 32'b10);
    tick();
    check("r_reset2", {31'd0, cpu_reset}, 32'd1);
    tick();
    check("r_run", {30'd0, cpu_reset, cpu_clk_en}, 32'b01);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("r_start_ignored", {30'd0, cpu_reset, busy}, 32'b01);
    tick();
    tick();
    #2 reset_n = 1'b0;
    #1;
    check("m_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("m_clk_en", {31'd0, cpu_clk_en}, 32'd0);
    check("m_flags", {28'd0, busy, done, pass, timeout}, 32'd0);
    check("m_count", {16'd0, cycle_count}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check("m_stays_idle", {30'd0, cpu_reset, busy}, 32'b10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
